fetch_stage: RTL

Instruction-fetch stage of the 16-bit pipelined processor, directly upstream of the decoder. It owns the 8-bit program counter, issues addresses to a synchronous-read instruction memory, and drives the IF/ID pipeline register (instruction, PC, PC+1) that the decoder consumes. It honours a decode-side stall without losing in-flight words, and accepts PC redirects from execute, flushing wrong-path words.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction memory and the IF/ID register.
// Optional zero-bubble jump predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_stage #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_1,
    output logic               predecode_jump
);

    localparam logic [3:0] OP_J = 4'd9;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e               state_q;
    logic [PC_W-1:0]      fetch_pc_q;
    logic                 inflight_valid_q;
    logic [PC_W-1:0]      inflight_pc_q;
    logic                 skid_valid_q;
    logic [INSTR_W-1:0]   skid_instr_q;
    logic [PC_W-1:0]      skid_pc_q;
    logic                 if_id_valid_q;
    logic [INSTR_W-1:0]   if_id_instr_q;
    logic [PC_W-1:0]      if_id_pc_q;
    logic [PC_W-1:0]      if_id_pc_1_q;

    logic                 load_valid;
    logic [INSTR_W-1:0]   load_instr;
    logic [PC_W-1:0]      load_pc;
    logic                 advance;
    logic                 jump_hit;
    logic [PC_W-1:0]      issue_addr;
    logic [PC_W-1:0]      fetch_pc_d;

    // The word entering IF/ID comes from memory in RUN and from the skid when leaving STALL.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        load_valid = inflight_valid_q;
        load_instr = imem_rdata;
        load_pc    = inflight_pc_q;
        if (state_q == STALL) begin
            load_valid = skid_valid_q;
            load_instr = skid_instr_q;
            load_pc    = skid_pc_q;
        end
    end

    assign advance = !redirect_valid && !stall;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign jump_hit = advance && load_valid && (load_instr[3:0] == OP_J);
`else
    assign jump_hit = 1'b0;
`endif

    always_comb begin
        issue_addr = fetch_pc_q;
        if (redirect_valid) begin
            issue_addr = redirect_pc;
        end else if (jump_hit) begin
            issue_addr = load_instr[4 +: PC_W];
        end
    end

    assign fetch_pc_d     = issue_addr + PC_W'(1);
    assign imem_en        = !rst && (redirect_valid || !stall);
    assign imem_addr      = rst ? '0 : issue_addr;
    assign predecode_jump = !rst && jump_hit;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            fetch_pc_q       <= '0;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            skid_valid_q     <= 1'b0;
            skid_instr_q     <= '0;
            skid_pc_q        <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= '0;
            if_id_pc_1_q     <= '0;
        end else if (redirect_valid) begin
            // Wrong-path words (in flight or skidded) are dropped; stall is ignored.
            state_q          <= RUN;
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= 1'b1;
            inflight_pc_q    <= issue_addr;
            skid_valid_q     <= 1'b0;
            if_id_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall) begin
                        skid_valid_q     <= inflight_valid_q;
                        skid_instr_q     <= imem_rdata;
                        skid_pc_q        <= inflight_pc_q;
                        inflight_valid_q <= 1'b0;
                        state_q          <= STALL;
                    end else begin
                        fetch_pc_q       <= fetch_pc_d;
                        inflight_valid_q <= 1'b1;
                        inflight_pc_q    <= issue_addr;
                        if_id_valid_q    <= load_valid;
                        if_id_instr_q    <= load_instr;
                        if_id_pc_q       <= load_pc;
                        if_id_pc_1_q     <= load_pc + PC_W'(1);
                    end
                end
                STALL: begin
                    if (!stall) begin
                        fetch_pc_q       <= fetch_pc_d;
                        inflight_valid_q <= 1'b1;
                        inflight_pc_q    <= issue_addr;
                        if_id_valid_q    <= load_valid;
                        if_id_instr_q    <= load_instr;
                        if_id_pc_q       <= load_pc;
                        if_id_pc_1_q     <= load_pc + PC_W'(1);
                        skid_valid_q     <= 1'b0;
                        state_q          <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc_1  = if_id_pc_1_q;

    // At most one word is ever buffered: a skidded word implies nothing is in flight.
    a_single_word: assert property (@(posedge clk) disable iff (rst)
        !(skid_valid_q && inflight_valid_q));
    a_stall_idle: assert property (@(posedge clk) disable iff (rst)
        (state_q == STALL) |-> !inflight_valid_q);

endmodule
